// File: rtl/bcd_timekeeper_pkg.sv
// Shared constants and BCD helpers for the BCD timekeeper and its field counters.
package bcd_timekeeper_pkg;

  localparam int unsigned BCD_W = 8;
  localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;

  // Legal BCD digits compare lexicographically, so a plain unsigned compare bounds the value.
  function automatic logic bcd_legal(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/bcd_timekeeper_field.sv
// Two-digit BCD counter with wrap at MAX, used for one time field (seconds, minutes or hours).
module bcd_field_counter
  import bcd_timekeeper_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = SEC_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  logic [BCD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    carry   = 1'b0;
    if (load) begin
      value_d = load_val;
    end else if (inc && !dec) begin
      if (value_q == MAX) begin
        value_d = '0;
        carry   = 1'b1;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end else if (dec && !inc) begin
      if (value_q == '0) begin
        value_d = MAX;
      end else if (value_q[3:0] == 4'd0) begin
        value_d = {value_q[7:4] - 4'd1, 4'd9};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day keeper: prescaled one-second advance, load, per-field edit and sticky alarm.
module bcd_timekeeper
  import bcd_timekeeper_pkg::*;
#(
  parameter int unsigned FIELDS   = 2,
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [8*FIELDS-1:0]        load_time,
  output logic                       load_err,
  input  logic [$clog2(FIELDS)-1:0]  edit_field,
  input  logic                       edit_up,
  input  logic                       edit_dn,
  input  logic [8*FIELDS-1:0]        alarm_time,
  input  logic                       alarm_arm,
  input  logic                       alarm_ack,
  output logic [8*FIELDS-1:0]        time_out,
  output logic                       tick,
  output logic                       alarm_hit,
  output logic                       wrap
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned EW = $clog2(FIELDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              load_err_q, load_err_d;
  logic              alarm_q, alarm_d;
  logic              upd_q, upd_d;
  logic [FIELDS-1:0] sel, legal, at_max, roll, f_inc, f_dec, carry;
  logic              load_acc, load_ok, edit_req, edit_inc, edit_dec;

  assign load_ready = !(edit_up || edit_dn);
  assign load_acc   = load_valid && load_ready;
  assign load_ok    = &legal;
  assign edit_req   = (edit_up || edit_dn) && |sel;
  assign edit_inc   = edit_req && edit_up && !edit_dn;
  assign edit_dec   = edit_req && edit_dn && !edit_up;
  // Loads and edits restart the second, so a coinciding tick is dropped.
  assign tick       = run && (cnt_q == CNT_LAST) && !load_acc && !edit_req;
  // Every field carries only when a tick rolls the whole time over.
  assign wrap       = &carry;

  for (genvar i = 0; i < FIELDS; i++) begin : g_field
    localparam logic [BCD_W-1:0] FMAX =
        (i == 0) ? SEC_MAX : (i == 1) ? MIN_MAX : to_bcd(HOUR_MAX);
    localparam logic [EW-1:0]     IDX   = EW'(i);
    localparam logic [FIELDS-1:0] LOWER = FIELDS'((1 << i) - 1);

    assign sel[i]    = (edit_field == IDX);
    assign legal[i]  = bcd_legal(load_time[BCD_W*i +: BCD_W], FMAX);
    assign at_max[i] = (time_out[BCD_W*i +: BCD_W] == FMAX);
    // A field advances on tick when all lower fields sit at their maximum.
    assign roll[i]   = &(at_max | ~LOWER);
    assign f_inc[i]  = (tick && roll[i]) || (edit_inc && sel[i]);
    assign f_dec[i]  = edit_dec && sel[i];

    bcd_field_counter #(
      .MAX(FMAX)
    ) u_field (
      .clk     (clk),
      .reset   (reset),
      .inc     (f_inc[i]),
      .dec     (f_dec[i]),
      .load    (load_acc && load_ok),
      .load_val(load_time[BCD_W*i +: BCD_W]),
      .value   (time_out[BCD_W*i +: BCD_W]),
      .carry   (carry[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_acc || edit_req) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
    upd_d      = (load_acc && load_ok) || edit_inc || edit_dec || tick;
    load_err_d = load_acc && !load_ok;
    alarm_d    = alarm_q;
    if (!alarm_arm || alarm_ack) begin
      alarm_d = 1'b0;
    end else if (upd_q && (time_out == alarm_time)) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      load_err_q <= 1'b0;
      alarm_q    <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
      alarm_q    <= alarm_d;
      upd_q      <= upd_d;
    end
  end

  assign load_err  = load_err_q;
  assign alarm_hit = alarm_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench: directed scenarios plus randomized traffic against a seconds-count model.
module tb_bcd_timekeeper;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // MM:SS instance, TICK_DIV=4
  logic        run = 0, lv = 0, up = 0, dn = 0, arm = 0, ack = 0;
  logic [0:0]  fld = '0;
  logic [15:0] tin = '0, alt = '0;
  logic        rdy, lerr, tck, ahit, wrp;
  logic [15:0] tout;

  // HH:MM:SS instance, TICK_DIV=3
  logic        run_b = 0, lv_b = 0;
  logic [1:0]  fld_b = '0;
  logic [23:0] tin_b = '0, alt_b = '0;
  logic        rdy_b, lerr_b, tck_b, ahit_b, wrp_b;
  logic [23:0] tout_b;

  bcd_timekeeper #(.FIELDS(2), .TICK_DIV(4), .HOUR_MAX(23)) dut (
    .clk(clk), .reset(reset), .run(run), .load_valid(lv), .load_ready(rdy), .load_time(tin),
    .load_err(lerr), .edit_field(fld), .edit_up(up), .edit_dn(dn), .alarm_time(alt),
    .alarm_arm(arm), .alarm_ack(ack), .time_out(tout), .tick(tck), .alarm_hit(ahit),
    .wrap(wrp)
  );

  bcd_timekeeper #(.FIELDS(3), .TICK_DIV(3), .HOUR_MAX(23)) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .load_valid(lv_b), .load_ready(rdy_b),
    .load_time(tin_b), .load_err(lerr_b), .edit_field(fld_b), .edit_up(1'b0),
    .edit_dn(1'b0), .alarm_time(alt_b), .alarm_arm(1'b0), .alarm_ack(1'b0),
    .time_out(tout_b), .tick(tck_b), .alarm_hit(ahit_b), .wrap(wrp_b)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model: time as a plain count of seconds within the hour.
  int m_tsec = 0, m_phase = 0;
  bit m_alarm = 0, m_upd = 0, m_lerr = 0;
  int n_tsec, n_phase;
  bit n_alarm, n_upd, n_lerr;
  bit e_tick, e_wrap, e_ready;

  function automatic logic [15:0] to_bcd16(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return 16'((mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + (ss % 10));
  endfunction

  task automatic model_eval();
    int mm, ss, step;
    int d[4];
    bit legal, lacc, ereq;
    e_ready = !(up || dn);
    lacc    = lv && e_ready;
    ereq    = up || dn;
    e_tick  = run && (m_phase == 3) && !lacc && !ereq;
    e_wrap  = e_tick && (m_tsec == 3599);
    if (!arm || ack) n_alarm = 0;
    else if (m_upd && (to_bcd16(m_tsec) == alt)) n_alarm = 1;
    else n_alarm = m_alarm;
    n_tsec = m_tsec; n_phase = m_phase; n_upd = 0; n_lerr = 0;
    mm = m_tsec / 60;
    ss = m_tsec % 60;
    if (lacc) begin
      for (int i = 0; i < 4; i++) d[i] = int'(tin[4*i +: 4]);
      legal = (d[0] <= 9) && (d[1] <= 9) && (d[2] <= 9) && (d[3] <= 9) &&
              (d[1] * 10 + d[0] <= 59) && (d[3] * 10 + d[2] <= 59);
      if (legal) n_tsec = (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
      n_upd = legal; n_lerr = !legal; n_phase = 0;
    end else if (ereq) begin
      n_phase = 0;
      if (up != dn) begin
        step = up ? 1 : 59;
        if (fld == 1'b0) ss = (ss + step) % 60;
        else mm = (mm + step) % 60;
        n_tsec = mm * 60 + ss;
        n_upd = 1;
      end
    end else begin
      if (run) n_phase = (m_phase + 1) % 4;
      if (e_tick) begin
        n_tsec = (m_tsec + 1) % 3600;
        n_upd = 1;
      end
    end
  endtask

  // Advance one clock; returns #1 after the rising edge with the model committed.
  task automatic clk_step();
    model_eval();
    @(posedge clk);
    #1;
    if (reset) begin
      m_tsec = 0; m_phase = 0; m_alarm = 0; m_upd = 0; m_lerr = 0;
    end else begin
      m_tsec = n_tsec; m_phase = n_phase; m_alarm = n_alarm; m_upd = n_upd; m_lerr = n_lerr;
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (tout !== 16'h0000) $display("FAIL reset_time: got %h expected 0000", tout);
    else pass_cnt++;
    chk_cnt++; if (tck !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tck); else pass_cnt++;
    chk_cnt++; if (wrp !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrp); else pass_cnt++;
    chk_cnt++; if (lerr !== 1'b0) $display("FAIL reset_lerr: got %b expected 0", lerr);
    else pass_cnt++;
    chk_cnt++; if (ahit !== 1'b0) $display("FAIL reset_alarm: got %b expected 0", ahit);
    else pass_cnt++;
    chk_cnt++; if (rdy !== 1'b1) $display("FAIL reset_ready: got %b expected 1", rdy);
    else pass_cnt++;
    clk_step();
    reset = 1'b0;
    clk_step();
  endtask

  task automatic test_count();
    int ticks = 0;
    run = 1; lv = 1; tin = 16'h0958;
    clk_step();
    lv = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (tck) ticks++;
      clk_step();
    end
    chk_cnt++; if (ticks !== 2) $display("FAIL count_ticks: got %0d expected 2", ticks);
    else pass_cnt++;
    chk_cnt++; if (tout !== 16'h1000) $display("FAIL count_time: got %h expected 1000", tout);
    else pass_cnt++;
    run = 0;
  endtask

  task automatic test_load_err();
    lv = 1; tin = 16'h1234;
    clk_step();
    tin = 16'h0A00;
    clk_step();
    chk_cnt++; if (lerr !== 1'b1) $display("FAIL lerr_nibble: got %b expected 1", lerr);
    else pass_cnt++;
    chk_cnt++; if (tout !== 16'h1234) $display("FAIL lerr_hold: got %h expected 1234", tout);
    else pass_cnt++;
    lv = 0;
    clk_step();
    chk_cnt++; if (lerr !== 1'b0) $display("FAIL lerr_pulse: got %b expected 0", lerr);
    else pass_cnt++;
    lv = 1; tin = 16'h0060;
    clk_step();
    chk_cnt++; if (lerr !== 1'b1) $display("FAIL lerr_range: got %b expected 1", lerr);
    else pass_cnt++;
    chk_cnt++; if (tout !== 16'h1234) $display("FAIL lerr_hold2: got %h expected 1234", tout);
    else pass_cnt++;
    lv = 0;
  endtask

  task automatic test_edit();
    lv = 1; tin = 16'h0000;
    clk_step();
    lv = 0; fld = 1'b0; dn = 1;
    #1;
    chk_cnt++; if (rdy !== 1'b0) $display("FAIL edit_ready: got %b expected 0", rdy);
    else pass_cnt++;
    clk_step();
    dn = 0;
    chk_cnt++; if (tout !== 16'h0059) $display("FAIL edit_dn: got %h expected 0059", tout);
    else pass_cnt++;
    lv = 1; tin = 16'h5930;
    clk_step();
    lv = 0; fld = 1'b1; up = 1;
    clk_step();
    up = 0;
    chk_cnt++; if (tout !== 16'h0030) $display("FAIL edit_up: got %h expected 0030", tout);
    else pass_cnt++;
  endtask

  task automatic test_alarm();
    alt = 16'h0005; arm = 1; ack = 0; run = 1; lv = 1; tin = 16'h0004;
    clk_step();
    lv = 0;
    for (int k = 0; k < 5; k++) clk_step();
    chk_cnt++; if (ahit !== 1'b1) $display("FAIL alarm_set: got %b expected 1", ahit);
    else pass_cnt++;
    run = 0;
    clk_step(); clk_step();
    chk_cnt++; if (ahit !== 1'b1) $display("FAIL alarm_hold: got %b expected 1", ahit);
    else pass_cnt++;
    ack = 1;
    clk_step();
    ack = 0;
    chk_cnt++; if (ahit !== 1'b0) $display("FAIL alarm_ack: got %b expected 0", ahit);
    else pass_cnt++;
    run = 1;
    #1;
    for (int k = 0; k < 8 && !tck; k++) clk_step();
    chk_cnt++; if (tck !== 1'b1) $display("FAIL alarm_tick_wait: got %b expected 1", tck);
    else pass_cnt++;
    lv = 1; tin = 16'h0030;
    #1;
    chk_cnt++; if (tck !== 1'b0) $display("FAIL load_vs_tick: got %b expected 0", tck);
    else pass_cnt++;
    clk_step();
    lv = 0; run = 0;
    chk_cnt++; if (tout !== 16'h0030) $display("FAIL load_vs_time: got %h expected 0030", tout);
    else pass_cnt++;
  endtask

  task automatic test_wrap_hms();
    lv_b = 1; tin_b = 24'h235959; run_b = 1;
    clk_step();
    lv_b = 0;
    chk_cnt++; if (tout_b !== 24'h235959) $display("FAIL hms_load: got %h expected 235959", tout_b);
    else pass_cnt++;
    clk_step(); clk_step();
    chk_cnt++; if (tck_b !== 1'b1) $display("FAIL hms_tick: got %b expected 1", tck_b);
    else pass_cnt++;
    chk_cnt++; if (wrp_b !== 1'b1) $display("FAIL hms_wrap: got %b expected 1", wrp_b);
    else pass_cnt++;
    clk_step();
    run_b = 0;
    chk_cnt++; if (tout_b !== 24'h000000) $display("FAIL hms_zero: got %h expected 000000", tout_b);
    else pass_cnt++;
    chk_cnt++; if (wrp_b !== 1'b0) $display("FAIL hms_wrap_end: got %b expected 0", wrp_b);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    lv = 1; tin = 16'h4321; run = 1;
    clk_step();
    lv = 0;
    clk_step(); clk_step();
    reset = 1;
    #1;
    chk_cnt++; if (tout !== 16'h0000) $display("FAIL rst_mid_time: got %h expected 0000", tout);
    else pass_cnt++;
    chk_cnt++; if (tck !== 1'b0) $display("FAIL rst_mid_tick: got %b expected 0", tck);
    else pass_cnt++;
    clk_step();
    reset = 0;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      if (k < 4) begin
        chk_cnt++;
        if (tck !== (k == 3)) $display("FAIL rst_first_tick c%0d: got %b expected %b", k, tck, k == 3);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (tout !== 16'h0001) $display("FAIL rst_first_adv: got %h expected 0001", tout);
    else pass_cnt++;
    run = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      run = ($urandom_range(0, 9) != 0);
      lv  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) tin = 16'h5959;
      else if ($urandom_range(0, 3) != 0) tin = to_bcd16(int'($urandom_range(0, 3599)));
      else tin = 16'($urandom);
      up  = ($urandom_range(0, 11) == 0);
      dn  = ($urandom_range(0, 11) == 0);
      fld = 1'($urandom_range(0, 1));
      arm = ($urandom_range(0, 19) != 0);
      ack = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) alt = to_bcd16((m_tsec + int'($urandom_range(1, 3))) % 3600);
      #1;
      model_eval();
      chk_cnt++; if (tck !== e_tick) $display("FAIL rnd_tick c%0d: got %b expected %b", c, tck, e_tick);
      else pass_cnt++;
      chk_cnt++; if (wrp !== e_wrap) $display("FAIL rnd_wrap c%0d: got %b expected %b", c, wrp, e_wrap);
      else pass_cnt++;
      chk_cnt++; if (rdy !== e_ready) $display("FAIL rnd_ready c%0d: got %b expected %b", c, rdy, e_ready);
      else pass_cnt++;
      clk_step();
      chk_cnt++;
      if (tout !== to_bcd16(m_tsec)) $display("FAIL rnd_time c%0d: got %h expected %h", c, tout, to_bcd16(m_tsec));
      else pass_cnt++;
      chk_cnt++; if (lerr !== m_lerr) $display("FAIL rnd_lerr c%0d: got %b expected %b", c, lerr, m_lerr);
      else pass_cnt++;
      chk_cnt++; if (ahit !== m_alarm) $display("FAIL rnd_alarm c%0d: got %b expected %b", c, ahit, m_alarm);
      else pass_cnt++;
    end
    run = 0; lv = 0; up = 0; dn = 0; ack = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_err();
    test_edit();
    test_alarm();
    test_wrap_hms();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
